// File: rtl/hazard_flush_ctrl_if.sv
// Hazard-control bundle between the MIPS pipeline (master) and the flush/stall
// controller (slave): resolved redirects and load-use operands in, controls out.
interface hazard_flush_ctrl_if #(
    parameter int STAGES = 4,
    parameter int CNT_W  = 16
);
    logic              branch_taken;
    logic              jump;
    logic [4:0]        id_rs;
    logic [4:0]        id_rt;
    logic              id_uses_rt;
    logic              ex_memread;
    logic [4:0]        ex_rt;
    logic [STAGES-1:0] flush;
    logic [STAGES-1:0] stall;
    logic              pc_en;
    logic [CNT_W-1:0]  flush_cnt;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output branch_taken, jump, id_rs, id_rt, id_uses_rt, ex_memread, ex_rt,
        input  flush, stall, pc_en, flush_cnt, stall_cnt
    );

    modport slave (
        input  branch_taken, jump, id_rs, id_rt, id_uses_rt, ex_memread, ex_rt,
        output flush, stall, pc_en, flush_cnt, stall_cnt
    );
endinterface

// File: rtl/hazard_flush_ctrl.sv
// Pipeline hazard controller: stage-indexed redirect flushes, load-use stalls,
// a post-redirect hold covering fetch latency, and saturating event counters.
module hazard_flush_ctrl #(
    parameter int STAGES       = 4,
    parameter int BR_STAGE     = 2,
    parameter int J_STAGE      = 1,
    parameter int REDIRECT_LAT = 2,
    parameter int CNT_W        = 16
) (
    input logic             clk,
    input logic             rst,
    hazard_flush_ctrl_if.slave hz
);

    localparam int                HOLD_W    = $clog2(REDIRECT_LAT) + 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(REDIRECT_LAT - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(1);
    localparam bit                USE_HOLD  = (REDIRECT_LAT > 1);
    localparam logic [STAGES-1:0] BR_MASK   = STAGES'((1 << BR_STAGE) - 1);
    localparam logic [STAGES-1:0] J_MASK    = STAGES'((1 << J_STAGE) - 1);
    localparam logic [STAGES-1:0] IF_ID     = STAGES'(1);
    localparam logic [STAGES-1:0] ID_EX     = STAGES'(2);

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_nxt;

    logic              lu_raw;
    logic              lu;
    logic              br_acc;
    logic              j_acc;
    logic              lu_stall;
    logic              redirect;

    logic [STAGES-1:0] flush_c;
    logic [STAGES-1:0] stall_c;
    logic              pc_en_c;
    logic [CNT_W-1:0]  flush_cnt_q;
    logic [CNT_W-1:0]  stall_cnt_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Hazard detection and priority: branch > load-use > jump.
    // ID carries a bubble during HOLD, so a load-use match there is spurious.
    assign lu_raw   = hz.ex_memread && (hz.ex_rt != 5'd0) &&
                      ((hz.ex_rt == hz.id_rs) || (hz.id_uses_rt && (hz.ex_rt == hz.id_rt)));
    assign lu       = lu_raw && (state == RUN);
    assign br_acc   = hz.branch_taken;
    assign lu_stall = lu && !br_acc;
    assign j_acc    = hz.jump && !lu && !br_acc;
    assign redirect = br_acc || j_acc;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RUN;
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_nxt;
        end
    end

    // Next-state logic: any accepted redirect (re)arms the hold window.
    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_cnt;
        if (redirect && USE_HOLD) begin
            state_nxt = HOLD;
            hold_nxt  = HOLD_LOAD;
        end else if (state == HOLD) begin
            if (hold_cnt <= HOLD_LAST) begin
                state_nxt = RUN;
                hold_nxt  = '0;
            end else begin
                hold_nxt  = hold_cnt - 1'b1;
            end
        end
    end

    // Output logic: combinational from inputs and state, reset forces all flush.
    always_comb begin
        flush_c = '0;
        stall_c = '0;
        pc_en_c = 1'b1;
        if (rst) begin
            flush_c = '1;
            pc_en_c = 1'b0;
        end else begin
            if (state == HOLD) begin
                flush_c = flush_c | IF_ID;
            end
            if (br_acc) begin
                flush_c = flush_c | BR_MASK;
            end else if (lu) begin
                stall_c[0] = 1'b1;
                flush_c    = flush_c | ID_EX;
                pc_en_c    = 1'b0;
            end else if (j_acc) begin
                flush_c = flush_c | J_MASK;
            end
            stall_c = stall_c & ~flush_c;
        end
    end

    // Event counters, updated on the edge that closes the event cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (redirect) begin
                flush_cnt_q <= sat_inc(flush_cnt_q);
            end
            if (lu_stall) begin
                stall_cnt_q <= sat_inc(stall_cnt_q);
            end
        end
    end

    assign hz.flush     = flush_c;
    assign hz.stall     = stall_c;
    assign hz.pc_en     = pc_en_c;
    assign hz.flush_cnt = flush_cnt_q;
    assign hz.stall_cnt = stall_cnt_q;

    a_no_overlap : assert property (@(posedge clk) disable iff (rst)
        (flush_c & stall_c) == '0);
    a_stall_if_only : assert property (@(posedge clk) disable iff (rst)
        (stall_c & ~IF_ID) == '0);
    a_pc_hold_is_stall : assert property (@(posedge clk) disable iff (rst)
        !pc_en_c |-> stall_c[0]);

endmodule

// File: tb/tb_hazard_flush_ctrl.sv
// Scoreboard bench for hazard_flush_ctrl: two instances (REDIRECT_LAT 2 / CNT_W 16
// and REDIRECT_LAT 3 / CNT_W 2) driven by the same directed and random stimulus.
module tb_hazard_flush_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       branch_taken = 1'b0;
    logic       jump = 1'b0;
    logic       id_uses_rt = 1'b0;
    logic       ex_memread = 1'b0;
    logic [4:0] id_rs = 5'd0;
    logic [4:0] id_rt = 5'd0;
    logic [4:0] ex_rt = 5'd0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    hazard_flush_ctrl_if #(.STAGES(4), .CNT_W(16)) ifa ();
    hazard_flush_ctrl_if #(.STAGES(4), .CNT_W(2))  ifb ();

    assign ifa.branch_taken = branch_taken;
    assign ifa.jump         = jump;
    assign ifa.id_rs        = id_rs;
    assign ifa.id_rt        = id_rt;
    assign ifa.id_uses_rt   = id_uses_rt;
    assign ifa.ex_memread   = ex_memread;
    assign ifa.ex_rt        = ex_rt;
    assign ifb.branch_taken = branch_taken;
    assign ifb.jump         = jump;
    assign ifb.id_rs        = id_rs;
    assign ifb.id_rt        = id_rt;
    assign ifb.id_uses_rt   = id_uses_rt;
    assign ifb.ex_memread   = ex_memread;
    assign ifb.ex_rt        = ex_rt;

    hazard_flush_ctrl #(
        .STAGES(4), .BR_STAGE(2), .J_STAGE(1), .REDIRECT_LAT(2), .CNT_W(16)
    ) dut_a (
        .clk(clk),
        .rst(rst),
        .hz (ifa)
    );

    hazard_flush_ctrl #(
        .STAGES(4), .BR_STAGE(2), .J_STAGE(1), .REDIRECT_LAT(3), .CNT_W(2)
    ) dut_b (
        .clk(clk),
        .rst(rst),
        .hz (ifb)
    );

    typedef struct packed {
        logic [3:0]  flush;
        logic [3:0]  stall;
        logic        pc_en;
        logic [15:0] fcnt;
        logic [15:0] scnt;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    // Reference model: hold is "within REDIRECT_LAT-1 cycles after the last
    // accepted redirect"; counters are plain integers clamped at their maximum.
    int lat[2]        = '{2, 3};
    int cmax[2]       = '{65535, 3};
    int last_redir[2] = '{-100, -100};
    int fc[2]         = '{0, 0};
    int sc[2]         = '{0, 0};

    task automatic model_step(input int k, output exp_t e);
        int age;
        bit in_hold;
        bit lu;
        e = '0;
        if (rst) begin
            e.flush       = 4'hF;
            e.pc_en       = 1'b0;
            last_redir[k] = -100;
            fc[k]         = 0;
            sc[k]         = 0;
        end else begin
            age     = cyc - last_redir[k];
            in_hold = (age >= 1) && (age <= lat[k] - 1);
            lu      = !in_hold && ex_memread && (ex_rt != 5'd0) &&
                      ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
            e.fcnt  = 16'(fc[k]);
            e.scnt  = 16'(sc[k]);
            e.pc_en = 1'b1;
            if (in_hold) e.flush[0] = 1'b1;
            if (branch_taken) begin
                e.flush[1:0]  = 2'b11;
                last_redir[k] = cyc;
                fc[k]         = (fc[k] < cmax[k]) ? fc[k] + 1 : fc[k];
            end else if (lu) begin
                e.stall[0] = 1'b1;
                e.flush[1] = 1'b1;
                e.pc_en    = 1'b0;
                sc[k]      = (sc[k] < cmax[k]) ? sc[k] + 1 : sc[k];
            end else if (jump) begin
                e.flush[0]    = 1'b1;
                last_redir[k] = cyc;
                fc[k]         = (fc[k] < cmax[k]) ? fc[k] + 1 : fc[k];
            end
        end
    endtask

    task automatic step(input logic r, input logic bt, input logic j, input logic mr,
                        input logic [4:0] ert, input logic [4:0] rs, input logic [4:0] rt,
                        input logic ur);
        exp_t ea;
        exp_t eb;
        @(posedge clk);
        #1;
        cyc++;
        rst = r; branch_taken = bt; jump = j; ex_memread = mr;
        ex_rt = ert; id_rs = rs; id_rt = rt; id_uses_rt = ur;
        model_step(0, ea);
        model_step(1, eb);
        q_a.push_back(ea);
        q_b.push_back(eb);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    endtask

    task automatic settle();
        @(negedge clk);
        #2;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic compare(input string name, input exp_t act, input exp_t e);
        checks++;
        if (act !== e) begin
            errors++;
            $display("FAIL %s cyc=%0d got flush=%b stall=%b pc_en=%b flush_cnt=%0d stall_cnt=%0d expected flush=%b stall=%b pc_en=%b flush_cnt=%0d stall_cnt=%0d",
                     name, cyc, act.flush, act.stall, act.pc_en, act.fcnt, act.scnt,
                     e.flush, e.stall, e.pc_en, e.fcnt, e.scnt);
        end
    endtask

    // Monitor: outputs are valid every cycle, compared mid-cycle against the queue.
    initial begin
        exp_t e;
        exp_t act;
        forever begin
            @(negedge clk);
            if (q_a.size() > 0) begin
                e   = q_a.pop_front();
                act = {ifa.flush, ifa.stall, ifa.pc_en, ifa.flush_cnt, ifa.stall_cnt};
                compare("dut_a", act, e);
            end
            if (q_b.size() > 0) begin
                e   = q_b.pop_front();
                act = {ifb.flush, ifb.stall, ifb.pc_en, 16'(ifb.flush_cnt), 16'(ifb.stall_cnt)};
                compare("dut_b", act, e);
            end
        end
    end

    initial begin
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        settle();
        check("rst_flush", 32'(ifa.flush), 32'hF);
        check("rst_pc_en", 32'(ifa.pc_en), 32'd0);
        idle(); idle();

        step(1'b0, 1'b0, 1'b0, 1'b1, 5'd8, 5'd8, 5'd0, 1'b0);
        settle();
        check("lu_stall", 32'(ifa.stall), 32'b0001);
        check("lu_flush", 32'(ifa.flush), 32'b0010);
        check("lu_pc_en", 32'(ifa.pc_en), 32'd0);
        idle(); settle();
        check("lu_stall_cnt", 32'(ifa.stall_cnt), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0);
        settle();
        check("lu_rt0_stall", 32'(ifa.stall), 32'd0);
        check("lu_rt0_pc_en", 32'(ifa.pc_en), 32'd1);
        idle();

        step(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        settle(); check("br_flush_t", 32'(ifa.flush), 32'b0011);
        idle(); settle(); check("br_flush_t1", 32'(ifa.flush), 32'b0001);
        idle(); settle(); check("br_flush_t2", 32'(ifa.flush), 32'b0000);
        check("br_flush_cnt", 32'(ifa.flush_cnt), 32'd1);

        step(1'b0, 1'b1, 1'b0, 1'b1, 5'd8, 5'd8, 5'd0, 1'b0);
        settle();
        check("brlu_flush", 32'(ifa.flush), 32'b0011);
        check("brlu_stall", 32'(ifa.stall), 32'd0);
        check("brlu_pc_en", 32'(ifa.pc_en), 32'd1);
        idle(); settle(); check("brlu_stall_cnt", 32'(ifa.stall_cnt), 32'd1);
        idle(); idle();

        step(1'b0, 1'b0, 1'b1, 1'b1, 5'd8, 5'd8, 5'd0, 1'b0);
        settle();
        check("jlu_stall", 32'(ifa.stall), 32'b0001);
        check("jlu_flush", 32'(ifa.flush), 32'b0010);
        check("jlu_pc_en", 32'(ifa.pc_en), 32'd0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        settle();
        check("j_flush", 32'(ifa.flush), 32'b0001);
        check("j_pc_en", 32'(ifa.pc_en), 32'd1);
        idle(); settle(); check("j_hold", 32'(ifa.flush), 32'b0001);
        idle(); settle(); check("j_run", 32'(ifa.flush), 32'b0000);
        idle(); idle();

        step(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        idle(); settle(); check("hold_ext_t2", 32'(ifb.flush), 32'b0001);
        idle(); settle(); check("hold_ext_t3", 32'(ifb.flush), 32'b0001);
        idle(); settle(); check("hold_ext_t4", 32'(ifb.flush), 32'b0000);
        check("flush_cnt_a", 32'(ifa.flush_cnt), 32'd5);
        check("flush_cnt_sat", 32'(ifb.flush_cnt), 32'd3);

        step(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        settle();
        check("midhold_rst_flush", 32'(ifa.flush), 32'hF);
        check("midhold_rst_stall", 32'(ifa.stall), 32'd0);
        check("midhold_rst_pc_en", 32'(ifa.pc_en), 32'd0);
        check("midhold_rst_fcnt", 32'(ifa.flush_cnt), 32'd0);
        check("midhold_rst_fcnt_b", 32'(ifb.flush_cnt), 32'd0);
        idle(); settle();
        check("post_rst_run_a", 32'(ifa.flush), 32'd0);
        check("post_rst_run_b", 32'(ifb.flush), 32'd0);

        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 5'd9, 5'd3, 5'd9, 1'b1);
        idle(); settle();
        check("stall_cnt_a", 32'(ifa.stall_cnt), 32'd5);
        check("stall_cnt_sat", 32'(ifb.stall_cnt), 32'd3);

        for (int i = 0; i < 3000; i++) begin
            logic [4:0] regs[3];
            regs[0] = 5'd0; regs[1] = 5'd8; regs[2] = 5'd9;
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 1) == 0),
                 regs[$urandom_range(0, 2)],
                 regs[$urandom_range(1, 2)] + 5'($urandom_range(0, 1)),
                 regs[$urandom_range(1, 2)] + 5'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)));
        end

        idle();
        settle();
        checks++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            errors++;
            $display("FAIL queue_drain got %0d/%0d pending expected 0/0", q_a.size(), q_b.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_flush_ctrl.md
# hazard_flush_ctrl

Parametrised pipeline hazard controller. It generates per-stage flush and stall controls and the PC write enable for the MIPS pipeline. It replaces the single-bit jump flush with:
- stage-indexed flushing for taken branches and jumps;
- load-use stall insertion;
- a multi-cycle redirect hold that covers fetch latency;
- saturating event counters.

It sits beside the pipeline registers and drives their flush/stall pins and the PC enable.

## Interface
- STAGES, 4: number of pipeline registers, index 0 = IF/ID, 1 = ID/EX, 2 = EX/MEM, 3 = MEM/WB
- BR_STAGE, 2: stage index where a branch resolves; 1 ≤ BR_STAGE < STAGES
- J_STAGE, 1: stage index where a jump resolves; 1 ≤ J_STAGE ≤ BR_STAGE
- REDIRECT_LAT, 2: fetch latency after a redirect, in cycles, ≥ 1
- CNT_W, 16: counter width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- branch_taken  in  1  taken branch resolved in stage BR_STAGE this cycle
- jump  in  1  jump resolved in stage J_STAGE this cycle
- id_rs  in  5  rs of the instruction in ID
- id_rt  in  5  rt of the instruction in ID
- id_uses_rt  in  1  ID instruction reads rt
- ex_memread  in  1  instruction in EX is a load
- ex_rt  in  5  destination of the load in EX
- flush  out  STAGES  bit i clears pipeline register i at the next edge
- stall  out  STAGES  bit i holds pipeline register i at the next edge
- pc_en  out  1  PC register write enable
- flush_cnt  out  CNT_W  accepted redirects, saturating
- stall_cnt  out  CNT_W  load-use stall cycles, saturating

## Operation
- FSM states: RUN and HOLD.
- HOLD keeps a down-counter hold_cnt, width clog2(REDIRECT_LAT)+1.
- **Load-use hazard (lu):** ex_memread && ex_rt != 0 && (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt)).
- **Priority:** branch_taken > lu > jump.
  - A branch flushes the younger jump and the stalled consumer.
  - A jump is ignored in any cycle where lu is asserted; it re-presents after the stall.
- **Branch accepted:**
  - flush[BR_STAGE-1:0] = all ones; stall = 0; pc_en = 1.
  - flush_cnt += 1.
  - If REDIRECT_LAT > 1: go to HOLD with hold_cnt = REDIRECT_LAT-1.
- **Jump accepted:**
  - flush[J_STAGE-1:0] = all ones; pc_en = 1.
  - flush_cnt += 1.
  - Same HOLD entry rule as a branch.
- **Load-use, no branch:**
  - stall[0] = 1; pc_en = 0; flush[1] = 1 (bubble into ID/EX).
  - stall_cnt += 1.
  - No state change.
- **HOLD:**
  - flush[0] = 1; pc_en = 1.
  - lu is suppressed, because ID holds a bubble.
  - hold_cnt decrements each cycle; return to RUN when it reaches 1 and no new redirect arrives.
- **Redirect during HOLD:** a branch or jump reloads hold_cnt = REDIRECT_LAT-1, ORs its own flush mask, and increments flush_cnt.
- **Overlap rule:** flush[i] and stall[i] are never both 1; flush wins.
- **Defaults:** stall[STAGES-1:1] = 0 always. flush bits at or above BR_STAGE are 0 except flush[1] from lu.
- **Counters:** saturate at 2^CNT_W-1; they do not wrap.

## Timing
- flush, stall and pc_en are combinational from the inputs and state, valid in the same cycle. Pipeline registers act on them at the next rising edge.
- Redirect latency:
  - Event in cycle t gives flush mask in t.
  - flush[0] = 1 in cycles t+1 .. t+REDIRECT_LAT-1.
  - RUN resumes in cycle t+REDIRECT_LAT.
- A load-use stall lasts exactly one cycle per hazard; lu deasserts once the load leaves EX.
- Counters update at the rising edge following the event cycle.
- **Reset, asynchronous, while rst = 1:**
  - state = RUN, hold_cnt = 0, flush_cnt = 0, stall_cnt = 0.
  - flush = all ones, stall = 0, pc_en = 0.
- **Reset mid-HOLD** aborts the hold. After rst deasserts, the first cycle is RUN.
- With REDIRECT_LAT = 1, HOLD is never entered.

## Test plan
- **Load-use.** Stimulus: ex_memread = 1, ex_rt = 8, id_rs = 8.
  - Response: stall = 4'b0001, flush = 4'b0010, pc_en = 0 for one cycle; stall_cnt = 1.
  - Repeat with ex_rt = 0: no stall.
- **Taken branch with defaults.** Stimulus: branch_taken pulse in cycle t.
  - Response: flush = 4'b0011 in t; flush = 4'b0001 in t+1; flush = 0 in t+2; flush_cnt = 1.
- **Branch and load-use together.** Stimulus: branch_taken and lu in the same cycle.
  - Response: flush = 4'b0011, stall = 0, pc_en = 1; stall_cnt unchanged.
- **Jump and load-use together.** Stimulus: jump and lu in the same cycle.
  - Response: stall only.
  - Next cycle, jump alone gives flush = 4'b0001, then one HOLD cycle.
- **Redirect during HOLD, REDIRECT_LAT = 3.** Stimulus: second branch at t+1.
  - Response: HOLD extends, with flush[0] = 1 through t+3; flush_cnt = 2.
- **Reset and saturation.**
  - Assert rst mid-HOLD: outputs go to reset values immediately.
  - With CNT_W = 2, apply 5 stalls: stall_cnt = 3.
